// File: rtl/bcd_decoder_if.sv
// rtl/bcd_decoder_if.sv - request/result bundle for the sequential BCD-to-binary converter.
interface bcd_decoder_if #(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 32
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [3:0]            ndigits;
  logic [BIN_W-1:0]      binary_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, bcd_in, ndigits,
    input  binary_out, busy, done, err
  );

  modport slave (
    input  start, bcd_in, ndigits,
    output binary_out, busy, done, err
  );
endinterface

// File: rtl/bcd_decoder.sv
// rtl/bcd_decoder.sv - Horner BCD-to-binary converter, one digit per clock, MS active digit first.
// Optional digit validation with abort is enabled by defining BCD_DEC_CHECK_EN.
module bcd_decoder #(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  bcd_decoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state, state_nxt;
  logic [4*DIGITS-1:0] bcd_q, bcd_nxt;
  logic [3:0]          idx, idx_nxt;
  logic [BIN_W-1:0]    acc, acc_nxt;
  logic [BIN_W-1:0]    out_q, out_nxt;
  logic                err_q, err_nxt;
  logic [3:0]          n_clamp;
  logic [3:0]          dig;
  logic [BIN_W-1:0]    mac;
  logic                bad;

  assign n_clamp = (bus.ndigits > 4'(DIGITS)) ? 4'(DIGITS) : bus.ndigits;

  always_comb begin
    dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 4'(i)) dig = bcd_q[4*i +: 4];
    end
  end

  // acc*10 as (acc<<3)+(acc<<1); the top bits fall off, giving the modulo-2^BIN_W wrap
  assign mac = {acc[BIN_W-4:0], 3'b000} + {acc[BIN_W-2:0], 1'b0} + BIN_W'(dig);

`ifdef BCD_DEC_CHECK_EN
  assign bad = (dig > 4'd9);
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    bcd_nxt   = bcd_q;
    idx_nxt   = idx;
    acc_nxt   = acc;
    out_nxt   = out_q;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          bcd_nxt = bus.bcd_in;
          acc_nxt = '0;
          err_nxt = 1'b0;
          if (n_clamp == 4'd0) begin
            out_nxt   = '0;
            state_nxt = DONE;
          end else begin
            idx_nxt   = n_clamp - 4'd1;
            state_nxt = CONV;
          end
        end
      end
      CONV: begin
        if (bad) begin
          err_nxt   = 1'b1;
          out_nxt   = '0;
          state_nxt = DONE;
        end else begin
          acc_nxt = mac;
          idx_nxt = idx - 4'd1;
          if (idx == 4'd0) begin
            // result is published on entry to DONE so it is valid alongside done
            out_nxt   = mac;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bcd_q <= '0;
      idx   <= '0;
      acc   <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      bcd_q <= bcd_nxt;
      idx   <= idx_nxt;
      acc   <= acc_nxt;
      out_q <= out_nxt;
      err_q <= err_nxt;
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.binary_out = out_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_bcd_decoder.sv
// tb/tb_bcd_decoder.sv - self-checking bench for bcd_decoder with a digit-level arithmetic model.
module tb_bcd_decoder;
  localparam int DIGITS = 8;
  localparam int BIN_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_decoder_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();
  bcd_decoder #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: value from the decimal meaning of the digits, plus the number of clocks until done
  function automatic void compute(input logic [4*DIGITS-1:0] b, input logic [3:0] nd,
                                  output logic [BIN_W-1:0] val, output logic e, output int len);
    int n;
    longint v;
    int d;
    n = (nd > DIGITS) ? DIGITS : int'(nd);
    v = 0;
    e = 1'b0;
    len = n + 1;
    for (int i = n - 1; i >= 0; i--) begin
      d = int'((b >> (4 * i)) & 4'hF);
`ifdef BCD_DEC_CHECK_EN
      if (d > 9) begin
        e = 1'b1;
        v = 0;
        len = (n - i) + 1;
        break;
      end
`endif
      v = (v * 10 + d) & ((64'd1 << BIN_W) - 1);
    end
    val = v[BIN_W-1:0];
  endfunction

  int               m_left = 0;
  logic [BIN_W-1:0] m_out = '0;
  logic             m_err = 1'b0;
  logic [BIN_W-1:0] p_val;
  logic             p_err;
  int               p_len;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_out  = '0;
      m_err  = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 1) begin
        m_out = p_val;
        m_err = p_err;
      end
    end else if (bus.start) begin
      compute(bus.bcd_in, bus.ndigits, p_val, p_err, p_len);
      m_err  = 1'b0;
      m_left = p_len;
      if (m_left == 1) begin
        m_out = p_val;
        m_err = p_err;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("done", 64'(bus.done), 64'(m_left == 1));
      check("busy", 64'(bus.busy), 64'(m_left > 0));
      check("binary_out", 64'(bus.binary_out), 64'(m_out));
      check("err", 64'(bus.err), 64'(m_err));
      if (bus.done) done_cnt++;
    end
  end

  task automatic run(input logic [31:0] b, input logic [3:0] nd, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd_in = b;
    bus.ndigits = nd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bcd_in = ~b;
    bus.ndigits = 4'd3;
    lat = 0;
    while (!bus.done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("timeout", 64'(lat < 50), 64'd1);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  int lat;
  int d0;

  initial begin
    bus.start = 1'b0;
    bus.bcd_in = '0;
    bus.ndigits = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out", 64'(bus.binary_out), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);

    // reset during a conversion must kill it without a done
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd_in = 32'h12345678;
    bus.ndigits = 4'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    check("rst_idle", 64'(bus.busy), 64'd0);
    run(32'h00000042, 4'd2, lat);
    check("t1_lat", 64'(lat), 64'd2);
    check("t1_val", 64'(bus.binary_out), 64'd42);
    check("t1_err", 64'(bus.err), 64'd0);
    settle();

    run(32'h99999999, 4'd8, lat);
    check("t2_lat", 64'(lat), 64'd8);
    check("t2_val", 64'(bus.binary_out), 64'h05F5E0FF);
    settle();

    run(32'h00001234, 4'd0, lat);
    check("t3a_lat", 64'(lat), 64'd0);
    check("t3a_val", 64'(bus.binary_out), 64'd0);
    settle();
    run(32'h00001234, 4'd12, lat);
    check("t3b_lat", 64'(lat), 64'd8);
    check("t3b_val", 64'(bus.binary_out), 64'd1234);
    settle();

    run(32'h99999995, 4'd1, lat);
    check("n1_lat", 64'(lat), 64'd1);
    check("n1_val", 64'(bus.binary_out), 64'd5);
    settle();
    run(32'h12345678, 4'd8, lat);
    check("n8_val", 64'(bus.binary_out), 64'd12345678);
    settle();

    // start held high: one result every n+2 = 3 clocks
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd_in = 32'h00000007;
    bus.ndigits = 4'd1;
    d0 = done_cnt;
    repeat (12) @(posedge clk);
    #1 bus.start = 1'b0;
    check("t4_dones", 64'(done_cnt - d0), 64'd4);
    repeat (3) @(posedge clk);
    #1;
    check("t4_val", 64'(bus.binary_out), 64'd7);
    check("t4_idle", 64'(bus.busy), 64'd0);

    run(32'h000001A3, 4'd3, lat);
`ifdef BCD_DEC_CHECK_EN
    check("t5_lat", 64'(lat), 64'd2);
    check("t5_val", 64'(bus.binary_out), 64'd0);
    check("t5_err", 64'(bus.err), 64'd1);
`else
    check("t5_lat", 64'(lat), 64'd3);
    check("t5_val", 64'(bus.binary_out), 64'd203);
    check("t5_err", 64'(bus.err), 64'd0);
`endif
    settle();

    run(32'h0000F0F0, 4'd4, lat);
`ifndef BCD_DEC_CHECK_EN
    check("hex_val", 64'(bus.binary_out), 64'd15150);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("hold_val", 64'(bus.binary_out), 64'(m_out));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
